// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch FSM states and architectural constants.
package rv32i_types;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned LINE_W = 64;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0060;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/fetch_align.sv
// Fetches 8-byte instruction lines and pushes their 32-bit words into the
// instruction queue one per cycle, honouring flush redirects and queue backpressure.
module fetch_align
    import rv32i_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [XLEN-1:0]   flush_pc,
    input  logic              inst_mem_resp,
    input  logic [LINE_W-1:0] inst_mem_rdata,
    output logic              inst_read,
    output logic [XLEN-1:0]   inst_mem_address,
    input  logic              iq_isfull,
    output logic              fetch_wen_inst,
    output logic [XLEN-1:0]   fetch_inst,
    output logic [XLEN-1:0]   fetch_pc,
    output logic [XLEN-1:0]   fetch_pc_next
);

    fetch_state_t      state;
    logic [XLEN-1:0]   pc;
    logic [LINE_W-1:0] line_buf;
    logic              slot;
    logic [XLEN-4:0]   req_line;

    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   flush_tgt;

    assign pc_inc    = pc + 32'd4;
    assign flush_tgt = flush_pc & ~32'h0000_0003;

    // req_line remembers the outstanding request while DISCARD waits it out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            line_buf <= '0;
            slot     <= 1'b0;
            req_line <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (flush) begin
                        pc       <= flush_tgt;
                        req_line <= pc[XLEN-1:3];
                        if (!inst_mem_resp) begin
                            state <= DISCARD;
                        end
                    end else if (inst_mem_resp) begin
                        line_buf <= inst_mem_rdata;
                        slot     <= pc[2];
                        state    <= DRAIN;
                    end
                end
                DISCARD: begin
                    if (flush) begin
                        pc <= flush_tgt;
                    end
                    if (inst_mem_resp) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        pc       <= flush_tgt;
                        line_buf <= '0;
                        state    <= FETCH;
                    end else if (!iq_isfull) begin
                        pc <= pc_inc;
                        if (slot) begin
                            state <= FETCH;
                        end else begin
                            slot <= 1'b1;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        inst_read        = 1'b0;
        inst_mem_address = '0;
        fetch_wen_inst   = 1'b0;
        fetch_inst       = '0;
        fetch_pc         = '0;
        fetch_pc_next    = '0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    inst_read        = 1'b1;
                    inst_mem_address = {pc[XLEN-1:3], 3'b000};
                end
                DISCARD: begin
                    inst_read        = 1'b1;
                    inst_mem_address = {req_line, 3'b000};
                end
                DRAIN: begin
                    fetch_inst     = slot ? line_buf[63:32] : line_buf[31:0];
                    fetch_pc       = pc;
                    fetch_pc_next  = pc_inc;
                    fetch_wen_inst = ~iq_isfull & ~flush;
                end
                default: begin
                    inst_read = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0060, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port flush  input  1  redirect request from the branch/commit path.
REQ-005 SHALL have port flush_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-006 SHALL have port inst_mem_resp  input  1  memory read done; rdata is valid this cycle.
REQ-007 SHALL have port inst_mem_rdata  input  64  aligned 8-byte instruction line.
REQ-008 SHALL have port inst_read  output  1  memory read request.
REQ-009 SHALL have port inst_mem_address  output  32  line address, bits [2:0] always 0.
REQ-010 SHALL have port iq_isfull  input  1  instruction queue cannot accept a push.
REQ-011 SHALL have port fetch_wen_inst  output  1  push strobe to the instruction queue.
REQ-012 SHALL have port fetch_inst  output  32  instruction word being pushed.
REQ-013 SHALL have port fetch_pc  output  32  PC of fetch_inst.
REQ-014 SHALL have port fetch_pc_next  output  32  fetch_pc+4, the sequential successor.

Function
REQ-015 SHALL hold a pc register, a 64-bit line buffer, a slot bit and a state register with states FETCH, DRAIN and DISCARD.
REQ-016 In FETCH: inst_read=1 and inst_mem_address={pc[31:3],3'b000}; address SHALL stay constant until inst_mem_resp.
REQ-017 FETCH, resp=1, flush=0: capture rdata into the buffer, set slot=pc[2], go to DRAIN.
REQ-018 FETCH, flush=1, resp=0: pc<=flush_pc; go to DISCARD (the outstanding read is not abandoned).
REQ-019 FETCH, flush=1 and resp=1 together: drop rdata, pc<=flush_pc, stay in FETCH; the new request issues the next cycle.
REQ-020 In DISCARD: inst_read=1, address unchanged from the original request; on resp, drop data and go to FETCH; a further flush only updates pc.
REQ-021 In DRAIN: fetch_inst = slot ? buffer[63:32] : buffer[31:0]; fetch_pc=pc; fetch_pc_next=pc+4 (mod 2^32); fetch_wen_inst = ~iq_isfull & ~flush.
REQ-022 DRAIN push: pc<=pc+4; if slot=0, then slot<=1 and stay in DRAIN; if slot=1, go to FETCH.
REQ-023 DRAIN with iq_isfull=1: hold all state and outputs stable; no push.
REQ-024 DRAIN with flush=1: no push, buffer discarded, pc<=flush_pc, go to FETCH; flush beats push.
REQ-025 A line entered at pc[2]=1 SHALL push only the upper word, so redirects to odd words never emit the lower word.
REQ-026 inst_read=0 in DRAIN; fetch_wen_inst=0 in FETCH and DISCARD; at most one push per cycle.
REQ-027 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no error.

Reset
REQ-028 rst SHALL set state=FETCH, pc=RESET_PC, slot=0, buffer=0 and override flush and resp in the same cycle.
REQ-029 While rst=1, inst_read and fetch_wen_inst SHALL be 0; fetch_inst, fetch_pc and fetch_pc_next SHALL be 0.
REQ-030 A fetch in flight when rst asserts SHALL be dropped; memory is reset by the same rst.

Structure
REQ-031 The fetch_state_t enum (FETCH, DRAIN, DISCARD) and the PC_RESET constant SHALL live in rv32i_types; the RESET_PC parameter defaults to PC_RESET.
REQ-032 No sub-module: one sequential process plus one combinational output decode.

Verification
REQ-033 After reset with 0-cycle memory latency and queue never full: 0x60, 0x64, 0x68... are pushed with correct words, one per cycle in DRAIN, and fetch_pc_next = fetch_pc+4.
REQ-034 flush_pc=0x104 in DRAIN at slot 0: no push that cycle; next request is at address 0x100; the first push is upper word, pc 0x104.
REQ-035 flush_pc=0x200 in FETCH with 3-cycle latency: address held at the old line until resp; that data is not pushed; the next request is 0x200.
REQ-036 flush and resp in the same cycle: nothing pushed; inst_read is high with address 0x200 on the next cycle.
REQ-037 iq_isfull held for 5 cycles in DRAIN: outputs stable, no push; the held word is pushed exactly once after release.
REQ-038 RESET_PC=0xFFFF_FFF8: pushes 0xFFFF_FFF8 and 0xFFFF_FFFC (fetch_pc_next 0x0), then requests address 0x0.
